mem_req_stage: RTL and testbench
================================

# mem_req_stage

Execute-to-memory request sequencer that sits directly upstream of `mem_stage`. It accepts one load or store per transaction from the execute stage and builds the `ren/raddr/funct3` or `wen/waddr/wdata/wmask` request. It holds that request stable until `mem_stage` returns `sig_memread_ok` / `sig_memwrite_ok`, then hands a one-cycle completion with the load data to writeback.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles; used only with `MEMREQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: execute presents a request.
- `req_ready` out 1: the stage can accept a request.
- `req_load` in 1: the request is a load.
- `req_store` in 1: the request is a store.
- `req_funct3` in 3: RISC-V funct3 (LB..LWU / SB..SD).
- `req_addr` in 64: effective address.
- `req_wdata` in 64: store source register value.
- `ren` out 1: read enable to `mem_stage`.
- `raddr` out 64: read address.
- `funct3` out 3: registered funct3 to `mem_stage`.
- `rdata` in 64: load result from `mem_stage`.
- `sig_memread_ok` in 1: read complete.
- `wen` out 1: write enable to `mem_stage`.
- `waddr` out 64: write address.
- `wdata` out 64: write data.
- `wmask` out 64: bit-granular write mask.
- `sig_memwrite_ok` in 1: write complete.
- `done` out 1: one-cycle completion pulse.
- `load_data` out 64: captured `rdata`; valid while `done` is high.
- `err` out 1: one-cycle error pulse, coincident with `done`.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. A request is accepted when `req_valid` is high, and all fields are registered on that edge.
  - `req_load` alone → READ.
  - `req_store` alone → WRITE.
  - Both or neither set → RESP with `err`=1; no memory access is made.
- READ: `ren`=1, `raddr`=addr, `funct3`=funct3. All three are held constant until `sig_memread_ok`, on which `rdata` is captured into `load_data` → RESP.
- WRITE: `wen`=1, `waddr`=addr, `funct3`=funct3.
  - `wmask` by funct3[1:0]: 00→0x00000000000000FF, 01→0x000000000000FFFF, 10→0x00000000FFFFFFFF, 11→all ones.
  - `wdata` = `req_wdata & wmask`. Data is not shifted; byte-lane alignment belongs to `mem_stage`.
  - Held until `sig_memwrite_ok` → RESP.
- RESP: `done`=1 for exactly one cycle → IDLE. `load_data` holds until the next accepted load.
- A store's `load_data` is left unchanged.
- `sig_memread_ok` in WRITE and `sig_memwrite_ok` in READ or IDLE are ignored.
- Misalignment is not checked here.
- Reset values: every output is 0, except `req_ready`=1. State resets to IDLE.
- Reset asserted mid-transaction: state is IDLE at the next edge and `ren`/`wen` drop there. No `done` is issued, and a late ok is ignored.

## Timing
- All outputs are registered.
- `req_ready` is low from the cycle after acceptance until back in IDLE.
- Accept edge N → `ren`/`wen` high in cycle N+1.
- Ok seen at edge M → `ren`/`wen` low and `done` high in cycle M+1.
- Minimum turnaround: an ok already high in the first request cycle gives `done` 2 cycles after acceptance, and the next acceptance one cycle after `done`.
- Throughput: at most one transaction per 3 cycles.
- Illegal request: `done`+`err` appear the cycle after acceptance.

## Configuration
- `MEMREQ_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to READ/WRITE and increments each waiting cycle.
  - Reaching `TIMEOUT_CYCLES` without an ok drops `ren`/`wen` and goes to RESP with `err`=1; `load_data` is unchanged.
- Not defined: no counter. The stage waits indefinitely, and `err` is driven only by illegal requests.

## Structure
- Shared package/defines: `BUS_64` / `BUS_8` widths, the state encoding constants, and the funct3 size constants (SB/SH/SW/SD) used to build masks.
- One natural sub-module, `store_mask_gen`: combinational funct3 → `wmask` / masked `wdata`.

## Test plan
- Load: addr=0x80000010, funct3=011, ok after 3 wait cycles, rdata=0x1122334455667788 → `ren` high for 4 cycles, raddr stable; `done` one cycle with `load_data`=0x1122334455667788, `err`=0.
- Store byte: funct3=000, wdata=0xDEADBEEFCAFEF00D → `wmask`=0xFF, `wdata`=0x0D, `wen` held until ok, then `done`=1.
- Store word then halfword back-to-back → masks 0xFFFFFFFF then 0xFFFF. `req_ready` stays low throughout each transaction, and no overlap of `wen` occurs.
- `req_load`=`req_store`=1 → `ren`=`wen`=0 throughout; `done`=`err`=1 in cycle N+1.
- `rst` pulsed while in READ → `ren`=0 and `req_ready`=1 after the edge; a later `sig_memread_ok` produces no `done`.
- With `MEMREQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, a load with no ok → `ren` drops after 4 waiting cycles, then `done`=`err`=1 and `load_data` is unchanged.

Source files
------------

// File: rtl/mem_req_stage_pkg.sv
// mem_req_stage_pkg: bus widths, FSM state encoding and store-size codes shared by mem_req_stage.
package mem_req_stage_pkg;
   localparam int BUS_64 = 64;
   localparam int BUS_8  = 8;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;
endpackage

// File: rtl/mem_req_stage_store_mask_gen.sv
// store_mask_gen: maps the store size to a bit-granular write mask and masks the store data.
module store_mask_gen
   import mem_req_stage_pkg::*;
(
   input  logic [1:0]        size,
   input  logic [BUS_64-1:0] data,
   output logic [BUS_64-1:0] mask,
   output logic [BUS_64-1:0] masked
);
   always_comb begin
      mask = size == SZ_B ? 64'h0000_0000_0000_00FF :
             size == SZ_H ? 64'h0000_0000_0000_FFFF :
             size == SZ_W ? 64'h0000_0000_FFFF_FFFF : '1;
      masked = data & mask;
   end
endmodule

// File: rtl/mem_req_stage.sv
// mem_req_stage: load/store request sequencer in front of mem_stage.
// Optional watchdog via MEMREQ_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module mem_req_stage
   import mem_req_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [BUS_64-1:0] req_addr,
   input  logic [BUS_64-1:0] req_wdata,
   output logic              ren,
   output logic [BUS_64-1:0] raddr,
   output logic [2:0]        funct3,
   input  logic [BUS_64-1:0] rdata,
   input  logic              sig_memread_ok,
   output logic              wen,
   output logic [BUS_64-1:0] waddr,
   output logic [BUS_64-1:0] wdata,
   output logic [BUS_64-1:0] wmask,
   input  logic              sig_memwrite_ok,
   output logic              done,
   output logic [BUS_64-1:0] load_data,
   output logic              err
);
   logic [1:0]        state;
   logic [BUS_64-1:0] mask_n, data_n;
   logic              ok;
   assign ok = state == S_READ ? sig_memread_ok : sig_memwrite_ok;
   store_mask_gen u_mask (
      .size  (req_funct3[1:0]),
      .data  (req_wdata),
      .mask  (mask_n),
      .masked(data_n)
   );
`ifdef MEMREQ_TIMEOUT_EN
   logic [BUS_8-1:0] cnt;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         req_ready <= 1'b1;
         ren       <= 1'b0;
         wen       <= 1'b0;
         raddr     <= '0;
         waddr     <= '0;
         wdata     <= '0;
         wmask     <= '0;
         funct3    <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         load_data <= '0;
`ifdef MEMREQ_TIMEOUT_EN
         cnt       <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               raddr     <= req_addr;
               waddr     <= req_addr;
               funct3    <= req_funct3;
               wmask     <= mask_n;
               wdata     <= data_n;
`ifdef MEMREQ_TIMEOUT_EN
               cnt       <= '0;
`endif
               // exactly one of load/store makes a legal request
               if (req_load ^ req_store) begin
                  ren   <= req_load;
                  wen   <= req_store;
                  state <= req_load ? S_READ : S_WRITE;
               end else begin
                  done  <= 1'b1;
                  err   <= 1'b1;
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: if (ok) begin
               if (state == S_READ) load_data <= rdata;
               ren   <= 1'b0;
               wen   <= 1'b0;
               done  <= 1'b1;
               state <= S_RESP;
            end
`ifdef MEMREQ_TIMEOUT_EN
            else if (cnt == BUS_8'(TIMEOUT_CYCLES - 1)) begin
               ren   <= 1'b0;
               wen   <= 1'b0;
               done  <= 1'b1;
               err   <= 1'b1;
               state <= S_RESP;
            end else cnt <= cnt + 1'b1;
`endif
         endcase
      end
   end
endmodule

// File: tb/tb_mem_req_stage.sv
// tb_mem_req_stage: directed self-checking bench for mem_req_stage (timeout case under MEMREQ_TIMEOUT_EN).
module tb_mem_req_stage;
   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_load, req_store;
   logic [2:0]  req_funct3, funct3;
   logic [63:0] req_addr, req_wdata, raddr, rdata, waddr, wdata, wmask, load_data;
   logic        ren, wen, sig_memread_ok, sig_memwrite_ok, done, err;
   int          n_run = 0, n_fail = 0;

   always #5 clk = ~clk;

   mem_req_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .ren(ren), .raddr(raddr),
      .funct3(funct3), .rdata(rdata), .sig_memread_ok(sig_memread_ok),
      .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask),
      .sig_memwrite_ok(sig_memwrite_ok), .done(done), .load_data(load_data), .err(err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd);
      req_valid = 1'b1; req_load = ld; req_store = st;
      req_funct3 = f3; req_addr = a; req_wdata = wd;
      step();
      req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
      req_addr = '0; req_wdata = '0; req_funct3 = '0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 0; req_load = 0; req_store = 0; req_funct3 = 0;
      req_addr = 0; req_wdata = 0; rdata = 0; sig_memread_ok = 0; sig_memwrite_ok = 0;
      step(); step();
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_ren", 64'(ren), 64'd0);
      check("rst_wen", 64'(wen), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_ldata", load_data, 64'd0);
      check("rst_wmask", wmask, 64'd0);
      rst = 1'b0;
      step();

      // load, ok after 3 wait cycles
      issue(1, 0, 3'b011, 64'h8000_0010, 64'h0);
      check("ld_funct3", 64'(funct3), 64'd3);
      check("ld_ready", 64'(req_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         check("ld_ren", 64'(ren), 64'd1);
         check("ld_raddr", raddr, 64'h8000_0010);
         check("ld_nodone", 64'(done), 64'd0);
         if (i == 3) begin sig_memread_ok = 1'b1; rdata = 64'h1122_3344_5566_7788; end
         step();
      end
      sig_memread_ok = 1'b0; rdata = '0;
      check("ld_ren_off", 64'(ren), 64'd0);
      check("ld_done", 64'(done), 64'd1);
      check("ld_err", 64'(err), 64'd0);
      check("ld_data", load_data, 64'h1122_3344_5566_7788);
      step();
      check("ld_done_off", 64'(done), 64'd0);
      check("ld_ready_back", 64'(req_ready), 64'd1);

      // store byte; a read ok during WRITE must be ignored
      issue(0, 1, 3'b000, 64'h8000_0100, 64'hDEAD_BEEF_CAFE_F00D);
      check("sb_wmask", wmask, 64'hFF);
      check("sb_wdata", wdata, 64'h0D);
      check("sb_waddr", waddr, 64'h8000_0100);
      check("sb_ren", 64'(ren), 64'd0);
      sig_memread_ok = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("sb_wen_hold", 64'(wen), 64'd1);
         check("sb_nodone", 64'(done), 64'd0);
      end
      sig_memread_ok = 1'b0; sig_memwrite_ok = 1'b1;
      step();
      sig_memwrite_ok = 1'b0;
      check("sb_wen_off", 64'(wen), 64'd0);
      check("sb_done", 64'(done), 64'd1);
      check("sb_ldata_kept", load_data, 64'h1122_3344_5566_7788);
      step();

      // store word then halfword at minimum turnaround
      issue(0, 1, 3'b010, 64'h8000_0200, 64'hDEAD_BEEF_CAFE_F00D);
      check("sw_wmask", wmask, 64'hFFFF_FFFF);
      check("sw_wdata", wdata, 64'hCAFE_F00D);
      check("sw_wen", 64'(wen), 64'd1);
      check("sw_ready", 64'(req_ready), 64'd0);
      sig_memwrite_ok = 1'b1;
      step();
      sig_memwrite_ok = 1'b0;
      check("sw_done", 64'(done), 64'd1);
      check("sw_wen_off", 64'(wen), 64'd0);
      check("sw_ready_resp", 64'(req_ready), 64'd0);
      step();
      check("sw_ready_back", 64'(req_ready), 64'd1);
      issue(0, 1, 3'b001, 64'h8000_0300, 64'hDEAD_BEEF_CAFE_F00D);
      check("sh_wmask", wmask, 64'hFFFF);
      check("sh_wdata", wdata, 64'hF00D);
      check("sh_ready", 64'(req_ready), 64'd0);
      sig_memwrite_ok = 1'b1;
      step();
      sig_memwrite_ok = 1'b0;
      check("sh_done", 64'(done), 64'd1);
      step();

      // illegal requests: both set, then neither set
      issue(1, 1, 3'b011, 64'h8000_0400, 64'h0);
      check("ill_done", 64'(done), 64'd1);
      check("ill_err", 64'(err), 64'd1);
      check("ill_ren", 64'(ren), 64'd0);
      check("ill_wen", 64'(wen), 64'd0);
      step();
      check("ill_done_off", 64'(done), 64'd0);
      check("ill_err_off", 64'(err), 64'd0);
      check("ill_ready", 64'(req_ready), 64'd1);
      issue(0, 0, 3'b000, 64'h8000_0500, 64'h0);
      check("none_err", 64'(err), 64'd1);
      check("none_ren", 64'(ren | wen), 64'd0);
      step();

      // reset while in READ, then a late ok
      issue(1, 0, 3'b010, 64'h8000_0600, 64'h0);
      check("rr_ren", 64'(ren), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rr_ren_off", 64'(ren), 64'd0);
      check("rr_ready", 64'(req_ready), 64'd1);
      sig_memread_ok = 1'b1; rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      step();
      check("rr_nodone", 64'(done), 64'd0);
      step();
      sig_memread_ok = 1'b0;
      check("rr_nodone2", 64'(done), 64'd0);
      check("rr_ldata", load_data, 64'd0);

`ifdef MEMREQ_TIMEOUT_EN
      issue(1, 0, 3'b011, 64'h8000_0700, 64'h0);
      for (int i = 0; i < 4; i++) begin
         check("to_ren", 64'(ren), 64'd1);
         step();
      end
      check("to_ren_off", 64'(ren), 64'd0);
      check("to_done", 64'(done), 64'd1);
      check("to_err", 64'(err), 64'd1);
      check("to_ldata", load_data, 64'd0);
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
